stim_player: RTL and testbench
==============================

STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 SHALL have parameter VEC_W, default 101, width of one stimulus vector.
REQ-002 SHALL have parameter DEPTH, default 8, number of vector entries.
REQ-003 SHALL have parameter AW, default 3, address width, with 2**AW >= DEPTH.
REQ-004 SHALL have parameter OBS_W, default 32, width of the observed response bus.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port load_en  input  1  write load_data to entry load_addr.
REQ-008 SHALL have port load_addr  input  AW  entry index for load.
REQ-009 SHALL have port load_data  input  VEC_W  vector to store.
REQ-010 SHALL have port start  input  1  begin playback (IDLE only).
REQ-011 SHALL have port stop  input  1  abort playback.
REQ-012 SHALL have port loop_en  input  1  restart from entry 0 after last vector.
REQ-013 SHALL have port len  input  AW+1  number of vectors to play, sampled at start.
REQ-014 SHALL have port vec_out  output  VEC_W  current vector, registered.
REQ-015 SHALL have port vec_valid  output  1  vec_out is a live vector.
REQ-016 SHALL have port vec_ready  input  1  consumer accepts vec_out this cycle.
REQ-017 SHALL have port obs_in  input  OBS_W  DUT response sampled on each accepted vector.
REQ-018 SHALL have port pc  output  AW  index of vector on vec_out.
REQ-019 SHALL have port busy  output  1  state is PLAY.
REQ-020 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-021 SHALL have port wrap_cnt  output  16  number of loop wraps, saturating.
REQ-022 SHALL have port obs_sig  output  OBS_W  rolling response signature.

Function
REQ-023 SHALL hold DEPTH x VEC_W vector storage; load_en writes only in IDLE with start low; load_addr >= DEPTH ignored.
REQ-024 SHALL implement states IDLE, PLAY, DONE.
REQ-025 IDLE + start + len!=0: latch L = min(len, DEPTH), pc<=0, vec_out<=entry0, vec_valid<=1, obs_sig<=0, wrap_cnt<=0, go PLAY; first vector visible the cycle after start.
REQ-026 IDLE + start + len==0: ignored, stay IDLE, no done.
REQ-027 start SHALL be ignored in PLAY and DONE.
REQ-028 PLAY, accept (vec_valid & vec_ready) with pc < L-1: pc<=pc+1, vec_out<=entry[pc+1].
REQ-029 PLAY, accept with pc == L-1 and loop_en=1: pc<=0, vec_out<=entry0, wrap_cnt+1 saturating at 16'hFFFF, stay PLAY.
REQ-030 PLAY, accept with pc == L-1 and loop_en=0: go DONE, vec_valid<=0, vec_out<=0.
REQ-031 PLAY without vec_ready: vec_out, pc, vec_valid hold.
REQ-032 on every accept, obs_sig <= rotl1(obs_sig) XOR obs_in.
REQ-033 stop in PLAY SHALL take priority over an accept that cycle: go IDLE, vec_valid<=0, vec_out<=0, pc<=0, no done, no obs_sig update; wrap_cnt and obs_sig hold.
REQ-034 DONE SHALL assert done for exactly one cycle, then go IDLE; stop in DONE has no effect.
REQ-035 busy = (state == PLAY); vec_valid is 1 only in PLAY.
REQ-036 obs_sig and wrap_cnt SHALL hold in IDLE and DONE until next accepted start.
REQ-037 L == 1 with loop_en=1 SHALL replay entry 0 every accepted cycle, wrap_cnt incrementing each accept.
REQ-038 loop_en SHALL be sampled at each last-vector accept, not latched at start.

Reset
REQ-039 reset low SHALL immediately force state IDLE, vec_out=0, vec_valid=0, pc=0, busy=0, done=0, wrap_cnt=0, obs_sig=0.
REQ-040 vector storage SHALL NOT be cleared by reset; contents survive reset mid-playback.
REQ-041 release of reset SHALL need no further action; next start behaves as REQ-025.

Verification
REQ-042 load entries 0..2 = 1,2,3; len=3, loop_en=0, vec_ready=1, start -> vec_out 1,2,3 on consecutive cycles, pc 0,1,2, then done=1 for one cycle, vec_valid=0.
REQ-043 same with loop_en=1 for 7 cycles -> vec_out 1,2,3,1,2,3,1, wrap_cnt=2, busy=1 throughout.
REQ-044 vec_ready low 3 cycles while vec_out=2 -> vec_out/pc hold 2/1, no obs_sig change; resume -> 3 then done.
REQ-045 obs_in=32'h1 on each of 3 accepts -> obs_sig sequence 1, 3, 7.
REQ-046 stop and vec_ready asserted together at pc=1 -> next cycle IDLE, vec_valid=0, pc=0, done never asserted.
REQ-047 reset low mid-playback at pc=2 -> outputs zero immediately; after release, start with len=3 replays 1,2,3 unchanged.

Source files
------------

// File: rtl/stim_player.sv
// Stimulus vector player: a small vector memory loaded while idle, played out
// through a valid/ready handshake, with optional looping, a saturating wrap
// counter and a rotate-xor signature of the responses seen on each accept.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; vector memory may be loaded
// PLAY  | vec_out holds a live vector, advancing on every accept
// DONE  | last vector accepted without looping; done pulses here
module stim_player #(
    parameter int VEC_W = 101,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int OBS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [VEC_W-1:0] load_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [AW:0]      len,
    output logic [VEC_W-1:0] vec_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    input  logic [OBS_W-1:0] obs_in,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             done,
    output logic [15:0]      wrap_cnt,
    output logic [OBS_W-1:0] obs_sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    state_t           state;
    logic [VEC_W-1:0] mem [DEPTH];
    logic [AW:0]      play_len;
    logic [AW:0]      len_clip;
    logic             last_vec;
    logic [AW-1:0]    pc_next;
    logic [OBS_W-1:0] sig_next;
    logic             load_ok;

    assign len_clip = (len > DEPTH_L) ? DEPTH_L : len;
    assign last_vec = ({1'b0, pc} == (play_len - 1'b1));
    assign pc_next  = pc + 1'b1;
    assign sig_next = {obs_sig[OBS_W-2:0], obs_sig[OBS_W-1]} ^ obs_in;
    assign load_ok  = load_en && (state == IDLE) && !start && (32'(load_addr) < DEPTH);
    assign busy     = (state == PLAY);

    // Vector storage: no reset so contents survive a reset mid-playback.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            play_len  <= '0;
            vec_out   <= '0;
            vec_valid <= 1'b0;
            pc        <= '0;
            done      <= 1'b0;
            wrap_cnt  <= '0;
            obs_sig   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && (len != '0)) begin
                        play_len  <= len_clip;
                        pc        <= '0;
                        vec_out   <= mem[0];
                        vec_valid <= 1'b1;
                        obs_sig   <= '0;
                        wrap_cnt  <= '0;
                        state     <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        // Abort wins over a simultaneous accept; signature is not updated.
                        vec_out   <= '0;
                        vec_valid <= 1'b0;
                        pc        <= '0;
                        state     <= IDLE;
                    end else if (vec_ready) begin
                        obs_sig <= sig_next;
                        if (!last_vec) begin
                            pc      <= pc_next;
                            vec_out <= mem[pc_next];
                        end else if (loop_en) begin
                            pc      <= '0;
                            vec_out <= mem[0];
                            if (wrap_cnt != 16'hFFFF) begin
                                wrap_cnt <= wrap_cnt + 16'd1;
                            end
                        end else begin
                            pc        <= '0;
                            vec_out   <= '0;
                            vec_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    vec_out   <= '0;
                    vec_valid <= 1'b0;
                    pc        <= '0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_player.sv
// Bench for stim_player: behavioural reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_stim_player;

    localparam int VEC_W = 101;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int OBS_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [VEC_W-1:0] load_data;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [AW:0]      len;
    logic [VEC_W-1:0] vec_out;
    logic             vec_valid;
    logic             vec_ready;
    logic [OBS_W-1:0] obs_in;
    logic [AW-1:0]    pc;
    logic             busy;
    logic             done;
    logic [15:0]      wrap_cnt;
    logic [OBS_W-1:0] obs_sig;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    stim_player #(.VEC_W(VEC_W), .DEPTH(DEPTH), .AW(AW), .OBS_W(OBS_W)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stop(stop), .loop_en(loop_en),
        .len(len), .vec_out(vec_out), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .obs_in(obs_in), .pc(pc), .busy(busy), .done(done), .wrap_cnt(wrap_cnt),
        .obs_sig(obs_sig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: "playing" flag, position in the sequence, and the
    // stored vectors; outputs are derived from these on demand.
    logic [VEC_W-1:0] m_mem [DEPTH];
    bit               m_playing = 0;
    bit               m_done    = 0;
    int               m_pos     = 0;
    int               m_len     = 0;
    int               m_wrap    = 0;
    logic [OBS_W-1:0] m_sig     = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_playing = 0;
            m_done    = 0;
            m_pos     = 0;
            m_wrap    = 0;
            m_sig     = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_playing) begin
            if (load_en && !start && int'(load_addr) < DEPTH)
                m_mem[load_addr] = load_data;
            if (start && len != 0) begin
                m_len     = (int'(len) > DEPTH) ? DEPTH : int'(len);
                m_pos     = 0;
                m_wrap    = 0;
                m_sig     = '0;
                m_playing = 1;
            end
        end else if (stop) begin
            m_playing = 0;
            m_pos     = 0;
        end else if (vec_ready) begin
            m_sig = ((m_sig << 1) | (m_sig >> (OBS_W - 1))) ^ obs_in;
            if (m_pos + 1 < m_len) begin
                m_pos = m_pos + 1;
            end else if (loop_en) begin
                m_pos  = 0;
                m_wrap = (m_wrap < 65535) ? m_wrap + 1 : 65535;
            end else begin
                m_playing = 0;
                m_done    = 1;
                m_pos     = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_vec_out",   vec_out,   m_playing ? m_mem[m_pos] : '0);
            chk("m_vec_valid", vec_valid, m_playing);
            chk("m_busy",      busy,      m_playing);
            chk("m_pc",        pc,        m_playing ? m_pos : 0);
            chk("m_done",      done,      m_done);
            chk("m_wrap_cnt",  wrap_cnt,  m_wrap);
            chk("m_obs_sig",   obs_sig,   m_sig);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int vals[7];
        reset = 1'b0; load_en = 0; load_addr = '0; load_data = '0;
        start = 0; stop = 0; loop_en = 0; len = '0; vec_ready = 0; obs_in = '0;
        tick(); tick();
        chk("rst_vec_out", vec_out, 0);
        chk("rst_valid", vec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap_cnt, 0);
        chk("rst_sig", obs_sig, 0);
        chk_on = 1'b1;
        reset = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1; load_addr = AW'(i);
            load_data = (i < 3) ? VEC_W'(i + 1) : VEC_W'(100 + i);
            tick();
        end
        load_en = 0;

        // Single pass, obs_in = 1 on each accept
        len = 4'd3; loop_en = 0; vec_ready = 1; obs_in = 32'h1; start = 1;
        tick(); start = 0;
        chk("p1_v0", vec_out, 1); chk("p1_pc0", pc, 0);
        tick();
        chk("p1_v1", vec_out, 2); chk("p1_pc1", pc, 1); chk("p1_sig1", obs_sig, 1);
        tick();
        chk("p1_v2", vec_out, 3); chk("p1_pc2", pc, 2); chk("p1_sig2", obs_sig, 3);
        tick();
        chk("p1_done", done, 1); chk("p1_valid", vec_valid, 0); chk("p1_sig3", obs_sig, 7);
        tick();
        chk("p1_done_off", done, 0); chk("p1_sig_hold", obs_sig, 7);

        // Looping for 7 cycles; a load attempt mid-play must be ignored
        vals = '{1, 2, 3, 1, 2, 3, 1};
        loop_en = 1; start = 1;
        tick(); start = 0;
        for (int k = 0; k < 7; k++) begin
            chk("p2_vec", vec_out, vals[k]);
            chk("p2_busy", busy, 1);
            load_en = (k == 2); load_addr = '0; load_data = VEC_W'(55);
            if (k < 6) tick();
        end
        load_en = 0;
        chk("p2_wrap", wrap_cnt, 2);
        stop = 1; tick(); stop = 0;
        chk("p2_stop_busy", busy, 0); chk("p2_wrap_hold", wrap_cnt, 2);

        // Backpressure while vec_out = 2
        loop_en = 0; start = 1; obs_in = 32'h5;
        tick(); start = 0;
        tick();
        chk("p3_v", vec_out, 2);
        vec_ready = 0; obs_in = 32'hA5A5;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("p3_hold_v", vec_out, 2); chk("p3_hold_pc", pc, 1); chk("p3_hold_sig", obs_sig, 32'h5);
        end
        vec_ready = 1;
        tick(); chk("p3_v3", vec_out, 3);
        tick(); chk("p3_done", done, 1);
        tick();

        // len = 0 ignored
        len = 4'd0; start = 1; tick(); start = 0;
        chk("p4_len0_busy", busy, 0); chk("p4_len0_done", done, 0);

        // Stop together with ready at pc=1; load with start high is ignored
        len = 4'd3; start = 1; load_en = 1; load_addr = 3'd1; load_data = VEC_W'(77);
        tick(); start = 0; load_en = 0;
        tick(); chk("p5_pc1", pc, 1); chk("p5_entry1", vec_out, 2);
        stop = 1; tick(); stop = 0;
        chk("p5_busy", busy, 0); chk("p5_valid", vec_valid, 0); chk("p5_pc", pc, 0);
        for (int k = 0; k < 3; k++) begin tick(); chk("p5_nodone", done, 0); end

        // L = 1 looping replays entry 0
        len = 4'd1; loop_en = 1; start = 1;
        tick(); start = 0;
        tick(); tick(); tick();
        chk("p6_vec", vec_out, 1); chk("p6_wrap", wrap_cnt, 3);
        loop_en = 0; tick();
        chk("p6_done", done, 1);
        stop = 1; tick(); stop = 0;
        chk("p6_idle", busy, 0);

        // len above DEPTH clips to DEPTH
        len = 4'd12; loop_en = 0; start = 1;
        tick(); start = 0;
        for (int k = 0; k < 7; k++) tick();
        chk("p7_last", vec_out, 107); chk("p7_pc", pc, 7);
        tick(); chk("p7_done", done, 1);
        tick();

        // Reset mid-playback at pc=2, then replay
        len = 4'd3; start = 1;
        tick(); start = 0;
        tick(); tick();
        chk("p8_pc2", pc, 2);
        #2 reset = 0;
        #1;
        chk("p8_rst_vec", vec_out, 0); chk("p8_rst_valid", vec_valid, 0);
        chk("p8_rst_pc", pc, 0); chk("p8_rst_busy", busy, 0); chk("p8_rst_sig", obs_sig, 0);
        tick(); reset = 1; tick();
        start = 1; tick(); start = 0;
        chk("p8_r1", vec_out, 1); tick();
        chk("p8_r2", vec_out, 2); tick();
        chk("p8_r3", vec_out, 3); tick();
        chk("p8_done", done, 1);

        // Mixed traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            tick();
            vec_ready = ($urandom_range(0, 3) != 0);
            obs_in    = $urandom;
            loop_en   = $urandom_range(0, 1);
            stop      = ($urandom_range(0, 15) == 0);
            start     = ($urandom_range(0, 3) == 0);
            len       = (AW + 1)'($urandom_range(0, 15));
        end
        start = 0; stop = 1;
        tick(); tick();
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
